led_fade_pwm: RTL and testbench

- Output stage placed directly downstream of the 4-LED rotating pattern generator.
- Takes the generator's 4-bit on/off pattern and drives the board LED pins through per-channel PWM.
- When a pattern bit changes, that LED ramps its brightness smoothly up or down instead of snapping on or off, so the chaser shows crossfading trails.
- Also provides a bypass mode and a fade-busy status flag.

---
 rtl/led_pkg.sv | 8 +
 rtl/led_fade_pwm_if.sv | 24 ++
 rtl/led_pwm_channel.sv | 52 +++++
 rtl/led_fade_pwm.sv | 65 ++++++
 tb/tb_led_fade_pwm.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Constants shared by the LED pattern generator and the fade/PWM output stage.
package led_pkg;

  localparam int unsigned LED_NUM          = 4;
  localparam int unsigned PWM_W_DEF        = 8;
  localparam logic [7:0]  FADE_PERIODS_DEF = 8'd4;

endpackage

// File: rtl/led_fade_pwm_if.sv
// Pattern-in / pin-out bundle between the pattern generator, the fade stage and the board.
interface led_fade_pwm_if;
  import led_pkg::*;

  logic [LED_NUM-1:0] led_in;
  logic               en;
  logic [LED_NUM-1:0] led_out;
  logic               fade_busy;

  modport master (
    output led_in,
    output en,
    input  led_out,
    input  fade_busy
  );

  modport slave (
    input  led_in,
    input  en,
    output led_out,
    output fade_busy
  );

endinterface

// File: rtl/led_pwm_channel.sv
// One LED channel: saturating duty ramp (or bypass), PWM compare and registered pin driver.
module led_pwm_channel #(
  parameter int unsigned PWM_W      = 8,
  parameter logic        ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_tgt,
  input  logic             i_en,
  input  logic             i_step_tick,
  input  logic [PWM_W-1:0] i_pwm_cnt,
  output logic             o_pin,
  output logic             o_busy
);

  localparam logic [PWM_W-1:0] DMAX = '1;

  logic [PWM_W-1:0] r_duty;
  logic [PWM_W-1:0] w_duty_next;
  logic             r_pin;
  logic             w_lit;

  always_comb begin
    w_duty_next = r_duty;
    if (!i_en) begin
      w_duty_next = i_tgt ? DMAX : '0;
    end else if (i_step_tick) begin
      // Saturating step toward the target extreme; a reversal just flips direction.
      if (i_tgt && (r_duty != DMAX)) begin
        w_duty_next = r_duty + 1'b1;
      end else if (!i_tgt && (r_duty != '0)) begin
        w_duty_next = r_duty - 1'b1;
      end
    end
  end

  // Full scale is forced lit so the LED is solid rather than dark for one cycle per period.
  assign w_lit  = (r_duty == DMAX) || (i_pwm_cnt < r_duty);
  assign o_busy = i_tgt ? (r_duty != DMAX) : (r_duty != '0);
  assign o_pin  = r_pin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty <= '0;
      r_pin  <= ACTIVE_LOW;
    end else begin
      r_duty <= w_duty_next;
      r_pin  <= w_lit ^ ACTIVE_LOW;
    end
  end

endmodule

// File: rtl/led_fade_pwm.sv
// LED output stage: per-channel PWM with smooth fade between pattern states, plus bypass.
module led_fade_pwm
  import led_pkg::*;
#(
  parameter int unsigned PWM_W        = PWM_W_DEF,
  parameter logic [7:0]  FADE_PERIODS = FADE_PERIODS_DEF,
  parameter logic        ACTIVE_LOW   = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  led_fade_pwm_if.slave  bus
);

  localparam logic [PWM_W-1:0] DMAX = '1;

  logic [PWM_W-1:0]   r_pwm_cnt;
  logic [7:0]         r_presc;
  logic [LED_NUM-1:0] r_tgt_q;
  logic               r_fade_busy;
  logic               w_per_tick;
  logic               w_presc_last;
  logic               w_step_tick;
  logic [LED_NUM-1:0] w_pin;
  logic [LED_NUM-1:0] w_busy;

  assign w_per_tick   = (r_pwm_cnt == DMAX);
  assign w_presc_last = (r_presc == (FADE_PERIODS - 8'd1));
  assign w_step_tick  = w_per_tick && w_presc_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt   <= '0;
      r_presc     <= '0;
      r_tgt_q     <= '0;
      r_fade_busy <= 1'b0;
    end else begin
      r_pwm_cnt   <= r_pwm_cnt + 1'b1;
      r_tgt_q     <= bus.led_in;
      r_fade_busy <= |w_busy;
      if (w_per_tick) begin
        r_presc <= w_presc_last ? 8'd0 : (r_presc + 8'd1);
      end
    end
  end

  for (genvar g = 0; g < LED_NUM; g++) begin : g_ch
    led_pwm_channel #(
      .PWM_W      (PWM_W),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_tgt       (r_tgt_q[g]),
      .i_en        (bus.en),
      .i_step_tick (w_step_tick),
      .i_pwm_cnt   (r_pwm_cnt),
      .o_pin       (w_pin[g]),
      .o_busy      (w_busy[g])
    );
  end

  assign bus.led_out   = w_pin;
  assign bus.fade_busy = r_fade_busy;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Directed bench: PWM_W=4, FADE_PERIODS=2 -> 16-cycle period, duty step every 32 cycles.
module tb_led_fade_pwm;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   n;
  int   lit_cnt [4];
  int   lit0;

  led_fade_pwm_if u_if ();

  led_fade_pwm #(
    .PWM_W        (4),
    .FADE_PERIODS (8'd2),
    .ACTIVE_LOW   (1'b1)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // n counts rising edges since the last reset release.
  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic run_to(input int target);
    while (n < target) tick();
  endtask

  // Count lit cycles per LED over the 16 edges following a step edge at 'start'.
  task automatic measure(input int start);
    run_to(start);
    for (int b = 0; b < 4; b++) lit_cnt[b] = 0;
    repeat (16) begin
      tick();
      for (int b = 0; b < 4; b++) if (u_if.led_out[b] == 1'b0) lit_cnt[b]++;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    n           = 0;
    rst_n       = 1'b1;
    u_if.led_in = 4'b0000;
    u_if.en     = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("reset_led_out", 32'(u_if.led_out), 32'hF);
    check("reset_busy", 32'(u_if.fade_busy), 32'h0);
    repeat (3) tick();
    check("reset_hold_led_out", 32'(u_if.led_out), 32'hF);
    rst_n = 1'b1;
    n = 0;

    // Idle with all targets dark.
    repeat (200) begin
      tick();
      check("idle_led_out", 32'(u_if.led_out), 32'hF);
      check("idle_busy", 32'(u_if.fade_busy), 32'h0);
    end

    // Fade up channel 0; steps land on edges 224, 256, ...
    u_if.led_in = 4'b0001;
    tick();
    tick();
    check("up_busy_rise", 32'(u_if.fade_busy), 32'h1);
    for (int k = 0; k < 14; k++) begin
      measure(224 + 32 * k);
      check("up_ch0_duty", 32'(lit_cnt[0]), 32'(k + 1));
    end
    measure(448);
    run_to(673);
    check("up_done_busy", 32'(u_if.fade_busy), 32'h0);
    repeat (32) begin
      tick();
      check("up_full_led_out", 32'(u_if.led_out), 32'hE);
    end

    // Crossfade ch0 down, ch1 up on shared steps starting at edge 736.
    run_to(710);
    u_if.led_in = 4'b0010;
    tick();
    tick();
    check("xf_busy", 32'(u_if.fade_busy), 32'h1);
    measure(928);
    check("xf_mid_ch0", 32'(lit_cnt[0]), 32'd8);
    check("xf_mid_ch1", 32'(lit_cnt[1]), 32'd7);
    measure(1152);
    check("xf_end_ch0", 32'(lit_cnt[0]), 32'd1);
    check("xf_end_ch1", 32'(lit_cnt[1]), 32'd14);
    run_to(1185);
    check("xf_done_led_out", 32'(u_if.led_out), 32'hD);
    check("xf_done_busy", 32'(u_if.fade_busy), 32'h0);
    repeat (32) begin
      tick();
      check("xf_steady_led_out", 32'(u_if.led_out), 32'hD);
    end

    // Reversal: ch0 rises to 5 (step at 1376), then target drops.
    run_to(1220);
    u_if.led_in = 4'b0011;
    run_to(1376);
    u_if.led_in = 4'b0000;
    measure(1376);
    check("rev_ch0_d5", 32'(lit_cnt[0]), 32'd5);
    measure(1408);
    check("rev_ch0_d4", 32'(lit_cnt[0]), 32'd4);
    check("rev_ch1_d14", 32'(lit_cnt[1]), 32'd14);
    measure(1440);
    check("rev_ch0_d3", 32'(lit_cnt[0]), 32'd3);
    measure(1472);
    check("rev_ch0_d2", 32'(lit_cnt[0]), 32'd2);
    measure(1504);
    check("rev_ch0_d1", 32'(lit_cnt[0]), 32'd1);
    measure(1536);
    check("rev_ch0_d0", 32'(lit_cnt[0]), 32'd0);
    lit0 = 0;
    while (n < 4736) begin
      tick();
      if (u_if.led_out[0] == 1'b0) lit0++;
    end
    check("sat_low_ch0_lit_cycles", 32'(lit0), 32'd0);
    check("sat_low_led_out", 32'(u_if.led_out), 32'hF);
    check("sat_low_busy", 32'(u_if.fade_busy), 32'h0);

    // Bypass: duty jumps straight to the target, pins follow 3 clk after the input.
    run_to(4740);
    u_if.en     = 1'b0;
    u_if.led_in = 4'b1010;
    tick();
    tick();
    check("byp_led_out_2clk", 32'(u_if.led_out), 32'hF);
    tick();
    check("byp_led_out_3clk", 32'(u_if.led_out), 32'h5);
    tick();
    check("byp_busy", 32'(u_if.fade_busy), 32'h0);
    check("byp_led_out_hold", 32'(u_if.led_out), 32'h5);
    run_to(4750);
    u_if.en     = 1'b1;
    u_if.led_in = 4'b0000;
    tick();
    tick();
    check("byp_exit_busy", 32'(u_if.fade_busy), 32'h1);
    run_to(4760);
    check("byp_exit_hold", 32'(u_if.led_out), 32'h5);
    measure(4768);
    check("byp_fade_ch1_d14", 32'(lit_cnt[1]), 32'd14);
    check("byp_fade_ch3_d14", 32'(lit_cnt[3]), 32'd14);
    measure(4800);
    check("byp_fade_ch1_d13", 32'(lit_cnt[1]), 32'd13);
    check("byp_fade_ch3_d13", 32'(lit_cnt[3]), 32'd13);

    // Reset mid-fade while ch2 sits at duty 9.
    run_to(4820);
    u_if.led_in = 4'b0100;
    measure(5088);
    check("mid_ch2_d9", 32'(lit_cnt[2]), 32'd9);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_led_out", 32'(u_if.led_out), 32'hF);
    check("async_rst_busy", 32'(u_if.fade_busy), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    n = 0;
    check("post_rst_led_out", 32'(u_if.led_out), 32'hF);
    measure(0);
    check("post_rst_ch2_d0", 32'(lit_cnt[2]), 32'd0);
    measure(32);
    check("post_rst_ch2_d1", 32'(lit_cnt[2]), 32'd1);
    measure(64);
    check("post_rst_ch2_d2", 32'(lit_cnt[2]), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
